// File: rtl/fake_n64_controller_rx.sv
// Joybus receive decoder for the fake N64 controller.
// Recovers console command bits from the oversampled data line by measuring
// each bit's low time, detects the STOP bit / end of frame, and presents the
// command byte plus optional address bytes with a one-cycle handoff pulse.
module fake_n64_controller_rx #(
   parameter int LEVEL_WIDTH = 2,
   parameter int BIT_WIDTH   = 4 * LEVEL_WIDTH,
   parameter int IDLE_CYCLES = 2 * BIT_WIDTH,
   parameter int MAX_LOW     = 4 * LEVEL_WIDTH
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        cur_operation,
   input  logic        data_rx,
   output logic [7:0]  cmd_byte,
   output logic [15:0] cmd_addr,
   output logic [5:0]  byte_count,
   output logic        cmd_valid,
   output logic        cmd_error,
   output logic        rx_busy
);

   // Low/high counters must be able to hold IDLE_CYCLES+1 before saturating.
   localparam int CNT_W = $clog2(IDLE_CYCLES + 2);
   localparam logic [CNT_W-1:0] CNT_MAX    = '1;
   localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
   localparam logic [CNT_W-1:0] IDLE_C     = CNT_W'(IDLE_CYCLES);
   localparam logic [CNT_W-1:0] MAX_LOW_C  = CNT_W'(MAX_LOW);
   // A low time shorter than two levels (half a bit) is a logical 1.
   localparam logic [CNT_W-1:0] ONE_THRESH = CNT_W'(2 * LEVEL_WIDTH);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_LOW,
      ST_HIGH,
      ST_WAIT_IDLE
   } state_t;

   logic        sync1_q;
   logic        sd_q;
   logic        sd_prev_q;
   state_t      state_q,      state_d;
   logic [CNT_W-1:0] low_cnt_q,  low_cnt_d;
   logic [CNT_W-1:0] high_cnt_q, high_cnt_d;
   logic [8:0]  bit_cnt_q,    bit_cnt_d;
   logic        pending_q,    pending_d;
   logic [23:0] shift_q,      shift_d;
   logic [7:0]  cmd_byte_q,   cmd_byte_d;
   logic [15:0] cmd_addr_q,   cmd_addr_d;
   logic [5:0]  byte_count_q, byte_count_d;
   logic        cmd_valid_q,  cmd_valid_d;
   logic        cmd_error_q,  cmd_error_d;

   logic             fall_edge;
   logic [CNT_W-1:0] low_inc;
   logic [CNT_W-1:0] high_inc;
   logic [8:0]       data_bits;
   logic             frame_good;

   assign fall_edge = sd_prev_q & ~sd_q;
   assign low_inc   = (low_cnt_q  == CNT_MAX) ? low_cnt_q  : low_cnt_q  + CNT_ONE;
   assign high_inc  = (high_cnt_q == CNT_MAX) ? high_cnt_q : high_cnt_q + CNT_ONE;
   // The pending bit at frame end is STOP, so data bits are one fewer than decoded.
   assign data_bits  = bit_cnt_q - 9'd1;
   assign frame_good = (bit_cnt_q >= 9'd9) && (bit_cnt_q[2:0] == 3'd1) && pending_q;

   // Two-flop synchronizer on the asynchronous line plus previous-sample for edges.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync1_q   <= 1'b1;
         sd_q      <= 1'b1;
         sd_prev_q <= 1'b1;
      end else begin
         sync1_q   <= data_rx;
         sd_q      <= sync1_q;
         sd_prev_q <= sd_q;
      end
   end

   // State, counters, bit buffer and output registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= ST_IDLE;
         low_cnt_q    <= '0;
         high_cnt_q   <= '0;
         bit_cnt_q    <= '0;
         pending_q    <= 1'b0;
         shift_q      <= '0;
         cmd_byte_q   <= '0;
         cmd_addr_q   <= '0;
         byte_count_q <= '0;
         cmd_valid_q  <= 1'b0;
         cmd_error_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         low_cnt_q    <= low_cnt_d;
         high_cnt_q   <= high_cnt_d;
         bit_cnt_q    <= bit_cnt_d;
         pending_q    <= pending_d;
         shift_q      <= shift_d;
         cmd_byte_q   <= cmd_byte_d;
         cmd_addr_q   <= cmd_addr_d;
         byte_count_q <= byte_count_d;
         cmd_valid_q  <= cmd_valid_d;
         cmd_error_q  <= cmd_error_d;
      end
   end

   // Next-state logic: bit timing, decode, frame-end evaluation and pulses.
   always_comb begin
      state_d      = state_q;
      low_cnt_d    = low_cnt_q;
      high_cnt_d   = high_cnt_q;
      bit_cnt_d    = bit_cnt_q;
      pending_d    = pending_q;
      shift_d      = shift_q;
      cmd_byte_d   = cmd_byte_q;
      cmd_addr_d   = cmd_addr_q;
      byte_count_d = byte_count_q;
      cmd_valid_d  = 1'b0;
      cmd_error_d  = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (!cur_operation && fall_edge) begin
               state_d   = ST_LOW;
               low_cnt_d = CNT_ONE;
               bit_cnt_d = '0;
               pending_d = 1'b0;
               shift_d   = '0;
            end
         end

         ST_LOW: begin
            if (cur_operation) begin
               // TX took the line: drop the frame silently.
               state_d = ST_IDLE;
            end else if (!sd_q) begin
               low_cnt_d = low_inc;
               if (low_inc > MAX_LOW_C) begin
                  cmd_error_d = 1'b1;
                  high_cnt_d  = '0;
                  state_d     = ST_WAIT_IDLE;
               end
            end else begin
               // Rising edge: commit the previous pending bit, hold the new one.
               if ((bit_cnt_q != 9'd0) && (bit_cnt_q <= 9'd24)) begin
                  shift_d = {shift_q[22:0], pending_q};
               end
               pending_d  = (low_cnt_q < ONE_THRESH);
               bit_cnt_d  = (bit_cnt_q == 9'h1FF) ? bit_cnt_q : bit_cnt_q + 9'd1;
               high_cnt_d = CNT_ONE;
               state_d    = ST_HIGH;
            end
         end

         ST_HIGH: begin
            if (cur_operation) begin
               state_d = ST_IDLE;
            end else if (!sd_q) begin
               state_d   = ST_LOW;
               low_cnt_d = CNT_ONE;
            end else begin
               high_cnt_d = high_inc;
               if (high_inc == IDLE_C) begin
                  state_d = ST_IDLE;
                  if (frame_good) begin
                     cmd_valid_d  = 1'b1;
                     byte_count_d = data_bits[8:3];
                     if (data_bits >= 9'd24) begin
                        cmd_byte_d = shift_q[23:16];
                        cmd_addr_d = shift_q[15:0];
                     end else if (data_bits >= 9'd16) begin
                        cmd_byte_d = shift_q[15:8];
                        cmd_addr_d = '0;
                     end else begin
                        cmd_byte_d = shift_q[7:0];
                        cmd_addr_d = '0;
                     end
                  end else begin
                     cmd_error_d = 1'b1;
                  end
               end
            end
         end

         ST_WAIT_IDLE: begin
            if (cur_operation) begin
               state_d = ST_IDLE;
            end else if (!sd_q) begin
               high_cnt_d = '0;
            end else begin
               high_cnt_d = high_inc;
               if (high_inc == IDLE_C) begin
                  state_d = ST_IDLE;
               end
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   assign cmd_byte   = cmd_byte_q;
   assign cmd_addr   = cmd_addr_q;
   assign byte_count = byte_count_q;
   assign cmd_valid  = cmd_valid_q;
   assign cmd_error  = cmd_error_q;
   assign rx_busy    = (state_q != ST_IDLE);

endmodule

// File: tb/tb_fake_n64_controller_rx.sv
// Bench for fake_n64_controller_rx: directed and random Joybus frames,
// expectations from a frame-level reference model.
module tb_fake_n64_controller_rx;

   logic        clk = 1'b0;
   logic        reset;
   logic        cur_operation;
   logic        data_rx;
   logic [7:0]  cmd_byte;
   logic [15:0] cmd_addr;
   logic [5:0]  byte_count;
   logic        cmd_valid;
   logic        cmd_error;
   logic        rx_busy;

   // Release of STOP at the pins -> 2 sync stages -> 16 high cycles at sd.
   localparam int LATENCY = 18;

   int checks   = 0;
   int failures = 0;

   int valid_total = 0;
   int error_total = 0;
   int both_total  = 0;
   int busy_total  = 0;

   // Reference model: outputs of the last good frame.
   logic [7:0]  m_byte = 8'h00;
   logic [15:0] m_addr = 16'h0000;
   logic [5:0]  m_cnt  = 6'd0;

   bit tx_bits[$];
   bit tx_stop;

   fake_n64_controller_rx dut (
      .clk           (clk),
      .reset         (reset),
      .cur_operation (cur_operation),
      .data_rx       (data_rx),
      .cmd_byte      (cmd_byte),
      .cmd_addr      (cmd_addr),
      .byte_count    (byte_count),
      .cmd_valid     (cmd_valid),
      .cmd_error     (cmd_error),
      .rx_busy       (rx_busy)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (cmd_valid) valid_total++;
      if (cmd_error) error_total++;
      if (cmd_valid && cmd_error) both_total++;
      if (rx_busy) busy_total++;
   end

   initial begin
      #5ms;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic idle(input int n);
      data_rx = 1'b1;
      repeat (n) @(negedge clk);
   endtask

   task automatic send_bit(input bit b);
      data_rx = 1'b0;
      repeat (b ? 2 : 6) @(negedge clk);
      data_rx = 1'b1;
      repeat (b ? 6 : 2) @(negedge clk);
   endtask

   task automatic push_byte(input logic [7:0] v);
      for (int i = 7; i >= 0; i--) tx_bits.push_back(v[i]);
   endtask

   // Frame-level rules: N = data bits + STOP; good if N>=9, data multiple of 8, STOP=1.
   task automatic model_frame(output bit good);
      int d;
      logic [7:0]  b;
      logic [15:0] a;
      d = tx_bits.size();
      good = (d + 1 >= 9) && (d % 8 == 0) && (tx_stop == 1'b1);
      if (good) begin
         b = 8'h00;
         for (int i = 0; i < 8; i++) b = {b[6:0], tx_bits[i]};
         a = 16'h0000;
         if (d >= 24) for (int i = 8; i < 24; i++) a = {a[14:0], tx_bits[i]};
         m_byte = b;
         m_addr = a;
         m_cnt  = (d / 8 > 63) ? 6'd63 : 6'(d / 8);
      end
   endtask

   // Drives tx_bits + STOP and observes the 40-cycle idle window that follows.
   task automatic run_frame(output int lat, output int nv, output int ne,
                            output logic [7:0] ob, output logic [15:0] oa,
                            output logic [5:0] oc);
      int v0, e0;
      v0 = valid_total;
      e0 = error_total;
      lat = -1;
      foreach (tx_bits[i]) send_bit(tx_bits[i]);
      data_rx = 1'b0;
      repeat (tx_stop ? 2 : 6) @(negedge clk);
      data_rx = 1'b1;
      for (int k = 1; k <= 40; k++) begin
         @(negedge clk);
         if (lat < 0 && (cmd_valid || cmd_error)) begin
            lat = k;
            ob  = cmd_byte;
            oa  = cmd_addr;
            oc  = byte_count;
         end
      end
      #1;
      nv = valid_total - v0;
      ne = error_total - e0;
      if (lat < 0) begin
         ob = cmd_byte;
         oa = cmd_addr;
         oc = byte_count;
      end
      $display("frame bits=%0d stop=%0d valid=%0d error=%0d lat=%0d byte=%02h addr=%04h cnt=%0d",
               tx_bits.size(), tx_stop, nv, ne, lat, ob, oa, oc);
   endtask

   task automatic test_reset();
      reset = 1'b0;
      cur_operation = 1'b0;
      data_rx = 1'b1;
      repeat (4) @(negedge clk);
      checks++; if (cmd_byte !== 8'h00) begin failures++; $display("FAIL reset_byte got=%02h exp=00", cmd_byte); end
      checks++; if (cmd_addr !== 16'h0000) begin failures++; $display("FAIL reset_addr got=%04h exp=0000", cmd_addr); end
      checks++; if (byte_count !== 6'd0) begin failures++; $display("FAIL reset_cnt got=%0d exp=0", byte_count); end
      checks++; if ({cmd_valid, cmd_error, rx_busy} !== 3'b000) begin failures++; $display("FAIL reset_flags got=%b exp=000", {cmd_valid, cmd_error, rx_busy}); end
      reset = 1'b1;
      idle(4);
      $display("reset busy=%0d byte=%02h addr=%04h cnt=%0d", rx_busy, cmd_byte, cmd_addr, byte_count);
   endtask

   task automatic test_single_zero();
      bit good; int lat, nv, ne; logic [7:0] ob; logic [15:0] oa; logic [5:0] oc;
      tx_bits.delete(); push_byte(8'h00); tx_stop = 1'b1;
      model_frame(good);
      run_frame(lat, nv, ne, ob, oa, oc);
      checks++; if (nv !== 1 || ne !== 0) begin failures++; $display("FAIL zero_pulses got valid=%0d error=%0d exp 1/0", nv, ne); end
      checks++; if (lat !== LATENCY) begin failures++; $display("FAIL zero_latency got=%0d exp=%0d", lat, LATENCY); end
      checks++; if ({ob, oa, oc} !== {8'h00, 16'h0000, 6'd1}) begin failures++; $display("FAIL zero_values got=%02h/%04h/%0d exp=00/0000/1", ob, oa, oc); end
   endtask

   task automatic test_back_to_back();
      bit good; int lat, nv, ne; logic [7:0] ob; logic [15:0] oa; logic [5:0] oc;
      int e0;
      e0 = error_total;
      tx_bits.delete(); push_byte(8'hFF); tx_stop = 1'b1;
      model_frame(good);
      run_frame(lat, nv, ne, ob, oa, oc);
      checks++; if (nv !== 1 || ob !== 8'hFF) begin failures++; $display("FAIL b2b_first got valid=%0d byte=%02h exp 1/FF", nv, ob); end
      tx_bits.delete(); push_byte(8'h01); tx_stop = 1'b1;
      model_frame(good);
      run_frame(lat, nv, ne, ob, oa, oc);
      checks++; if (nv !== 1 || ob !== 8'h01 || oc !== 6'd1) begin failures++; $display("FAIL b2b_second got valid=%0d byte=%02h cnt=%0d exp 1/01/1", nv, ob, oc); end
      checks++; if (error_total != e0) begin failures++; $display("FAIL b2b_error got=%0d exp=0", error_total - e0); end
   endtask

   task automatic test_address();
      bit good; int lat, nv, ne; logic [7:0] ob; logic [15:0] oa; logic [5:0] oc;
      tx_bits.delete(); push_byte(8'h02); push_byte(8'h80); push_byte(8'h01); tx_stop = 1'b1;
      model_frame(good);
      run_frame(lat, nv, ne, ob, oa, oc);
      checks++; if (nv !== 1 || ne !== 0) begin failures++; $display("FAIL addr_pulses got valid=%0d error=%0d exp 1/0", nv, ne); end
      checks++; if ({ob, oa, oc} !== {8'h02, 16'h8001, 6'd3}) begin failures++; $display("FAIL addr_values got=%02h/%04h/%0d exp=02/8001/3", ob, oa, oc); end
   endtask

   task automatic test_bad_length();
      bit good; int lat, nv, ne; logic [7:0] ob; logic [15:0] oa; logic [5:0] oc;
      tx_bits.delete(); push_byte(8'h00); tx_bits.push_back(1'b0); tx_stop = 1'b1;
      model_frame(good);
      run_frame(lat, nv, ne, ob, oa, oc);
      checks++; if (ne !== 1 || nv !== 0) begin failures++; $display("FAIL badlen_pulses got valid=%0d error=%0d exp 0/1", nv, ne); end
      checks++; if (lat !== LATENCY) begin failures++; $display("FAIL badlen_latency got=%0d exp=%0d", lat, LATENCY); end
      checks++; if ({cmd_byte, cmd_addr, byte_count} !== {8'h02, 16'h8001, 6'd3}) begin failures++; $display("FAIL badlen_hold got=%02h/%04h/%0d exp=02/8001/3", cmd_byte, cmd_addr, byte_count); end
   endtask

   task automatic test_stuck_low();
      bit good; int lat, nv, ne; logic [7:0] ob; logic [15:0] oa; logic [5:0] oc;
      int v0, e0;
      v0 = valid_total; e0 = error_total;
      send_bit(1'b1);
      send_bit(1'b0);
      data_rx = 1'b0;
      repeat (12) @(negedge clk);
      idle(40);
      $display("stuck valid=%0d error=%0d", valid_total - v0, error_total - e0);
      checks++; if (error_total - e0 !== 1) begin failures++; $display("FAIL stuck_error got=%0d exp=1", error_total - e0); end
      checks++; if (valid_total - v0 !== 0) begin failures++; $display("FAIL stuck_valid got=%0d exp=0", valid_total - v0); end
      tx_bits.delete(); push_byte(8'h01); tx_stop = 1'b1;
      model_frame(good);
      run_frame(lat, nv, ne, ob, oa, oc);
      checks++; if (nv !== 1 || ne !== 0 || lat !== LATENCY) begin failures++; $display("FAIL stuck_recover got valid=%0d error=%0d lat=%0d exp 1/0/%0d", nv, ne, lat, LATENCY); end
      checks++; if ({ob, oa, oc} !== {8'h01, 16'h0000, 6'd1}) begin failures++; $display("FAIL stuck_values got=%02h/%04h/%0d exp=01/0000/1", ob, oa, oc); end
   endtask

   task automatic test_handoff();
      bit good; int lat, nv, ne; logic [7:0] ob; logic [15:0] oa; logic [5:0] oc;
      int b0;
      // Full frame while TX owns the line.
      cur_operation = 1'b1;
      b0 = busy_total;
      tx_bits.delete(); push_byte(8'h00); tx_stop = 1'b1;
      run_frame(lat, nv, ne, ob, oa, oc);
      checks++; if (nv !== 0 || ne !== 0) begin failures++; $display("FAIL handoff_pulses got valid=%0d error=%0d exp 0/0", nv, ne); end
      checks++; if (busy_total != b0) begin failures++; $display("FAIL handoff_busy got=%0d busy cycles exp=0", busy_total - b0); end
      // Handoff in the middle of a frame: immediate abort.
      cur_operation = 1'b0;
      idle(4);
      for (int i = 0; i < 3; i++) send_bit(1'b0);
      checks++; if (rx_busy !== 1'b1) begin failures++; $display("FAIL handoff_midbusy got=%b exp=1", rx_busy); end
      cur_operation = 1'b1;
      @(negedge clk);
      checks++; if (rx_busy !== 1'b0) begin failures++; $display("FAIL handoff_abort got=%b exp=0", rx_busy); end
      tx_bits.delete(); for (int i = 0; i < 5; i++) tx_bits.push_back(1'b0); tx_stop = 1'b1;
      run_frame(lat, nv, ne, ob, oa, oc);
      checks++; if (nv !== 0 || ne !== 0) begin failures++; $display("FAIL handoff_mid_pulses got valid=%0d error=%0d exp 0/0", nv, ne); end
      cur_operation = 1'b0;
      idle(4);
   endtask

   task automatic test_reset_mid_frame();
      int v0, e0;
      v0 = valid_total; e0 = error_total;
      for (int i = 0; i < 4; i++) send_bit(1'b0);
      checks++; if (rx_busy !== 1'b1) begin failures++; $display("FAIL rstmid_busy_before got=%b exp=1", rx_busy); end
      reset = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b1;
      m_byte = 8'h00; m_addr = 16'h0000; m_cnt = 6'd0;
      idle(40);
      $display("reset_mid valid=%0d error=%0d busy=%0d", valid_total - v0, error_total - e0, rx_busy);
      checks++; if (valid_total != v0 || error_total != e0) begin failures++; $display("FAIL rstmid_pulses got valid=%0d error=%0d exp 0/0", valid_total - v0, error_total - e0); end
      checks++; if (rx_busy !== 1'b0) begin failures++; $display("FAIL rstmid_busy got=%b exp=0", rx_busy); end
      checks++; if ({cmd_byte, cmd_addr, byte_count} !== {m_byte, m_addr, m_cnt}) begin failures++; $display("FAIL rstmid_values got=%02h/%04h/%0d exp=00/0000/0", cmd_byte, cmd_addr, byte_count); end
   endtask

   task automatic test_max_bytes();
      bit good; int lat, nv, ne; logic [7:0] ob; logic [15:0] oa; logic [5:0] oc;
      tx_bits.delete();
      for (int i = 0; i < 63; i++) push_byte(8'($urandom));
      tx_stop = 1'b1;
      model_frame(good);
      run_frame(lat, nv, ne, ob, oa, oc);
      checks++; if (nv !== 1 || ne !== 0) begin failures++; $display("FAIL max_pulses got valid=%0d error=%0d exp 1/0", nv, ne); end
      checks++; if ({ob, oa, oc} !== {m_byte, m_addr, m_cnt}) begin failures++; $display("FAIL max_values got=%02h/%04h/%0d exp=%02h/%04h/%0d", ob, oa, oc, m_byte, m_addr, m_cnt); end
   endtask

   task automatic test_random();
      bit good; int lat, nv, ne; logic [7:0] ob; logic [15:0] oa; logic [5:0] oc;
      int mode, n;
      for (int t = 0; t < 24; t++) begin
         tx_bits.delete();
         mode = $urandom_range(0, 2);
         if (mode < 2) begin
            n = $urandom_range(1, 4);
            for (int i = 0; i < n; i++) push_byte(8'($urandom));
            tx_stop = 1'b1;
         end else begin
            n = $urandom_range(0, 40);
            for (int i = 0; i < n; i++) tx_bits.push_back(1'($urandom));
            tx_stop = 1'($urandom);
         end
         model_frame(good);
         run_frame(lat, nv, ne, ob, oa, oc);
         checks++; if (nv !== (good ? 1 : 0) || ne !== (good ? 0 : 1)) begin failures++; $display("FAIL rand%0d_pulses got valid=%0d error=%0d exp good=%0d", t, nv, ne, good); end
         checks++; if (lat !== LATENCY) begin failures++; $display("FAIL rand%0d_latency got=%0d exp=%0d", t, lat, LATENCY); end
         checks++; if ({ob, oa, oc} !== {m_byte, m_addr, m_cnt}) begin failures++; $display("FAIL rand%0d_values got=%02h/%04h/%0d exp=%02h/%04h/%0d", t, ob, oa, oc, m_byte, m_addr, m_cnt); end
      end
   endtask

   initial begin
      test_reset();
      test_single_zero();
      test_back_to_back();
      test_address();
      test_bad_length();
      test_stuck_low();
      test_handoff();
      test_reset_mid_frame();
      test_random();
      test_max_bytes();
      checks++; if (both_total != 0) begin failures++; $display("FAIL valid_error_overlap got=%0d exp=0", both_total); end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
